mem_port_arbiter: RTL and testbench

- Shares the core's memory-mapped load/store space (DMEM, BIOS, IO) between two requesters: port 0 (CPU data port) and port 1 (UART bootloader/DMA engine).
- Grants one access per cycle and drives the memory enables.
- Tracks the region and owner of each read, so the synchronous-read data returns to the correct requester one cycle later.
- Holds IO accesses in a wait state until the IO block acknowledges.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_region_decode.sv | 19 +
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package arb_pkg;

    localparam int OWN_W = 1;

    typedef enum logic [1:0] {
        REG_DMEM = 2'd0,
        REG_BIOS = 2'd1,
        REG_IO   = 2'd2,
        REG_NONE = 2'd3
    } region_t;

    localparam logic [3:0] NIB_DMEM0 = 4'b0001;
    localparam logic [3:0] NIB_DMEM1 = 4'b0011;
    localparam logic [3:0] NIB_BIOS  = 4'b0100;
    localparam logic [3:0] NIB_IO    = 4'b1000;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_IO_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_port_arbiter_region_decode.sv
// Maps the top address nibble of an access to its target region.
module region_decode
    import arb_pkg::*;
(
    input  logic [3:0] nib,
    output region_t    region
);

    always_comb begin
        region = REG_NONE;
        case (nib)
            NIB_DMEM0, NIB_DMEM1: region = REG_DMEM;
            NIB_BIOS:             region = REG_BIOS;
            NIB_IO:               region = REG_IO;
            default:              region = REG_NONE;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the DMEM/BIOS/IO load-store space with read return routing.
// Build option: ARB_CPU_PRIORITY_EN makes port 0 win every tie (fixed priority).
//
// state      | meaning
// ST_IDLE    | grants issued combinationally, one access per cycle
// ST_IO_WAIT | IO access outstanding, no grants until io_ack
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [3:0]    m0_we,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [3:0]    m1_we,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          dmem_en,
    output logic [3:0]    dmem_we,
    output logic          bios_en,
    output logic          io_req,
    output logic          io_we,
    input  logic          io_ack,
    input  logic [DW-1:0] dmem_dout,
    input  logic [DW-1:0] bios_dout,
    input  logic [DW-1:0] io_dout
);

    state_t             state_q, state_d;
    logic               last_q;
    logic               rv_q, rv_d;
    logic [OWN_W-1:0]   rv_own_q, rv_own_d;
    region_t            rv_reg_q, rv_reg_d;
    logic [DW-1:0]      io_data_q, io_data_d;
    logic [AW-1:0]      io_addr_q;
    logic [DW-1:0]      io_wdata_q;
    logic               io_we_q;
    logic [OWN_W-1:0]   io_own_q;

    logic               any_req, sel, grant, g_read, g_io;
    logic [AW-1:0]      g_addr;
    logic [DW-1:0]      g_wdata;
    logic [3:0]         g_we;
    region_t            g_reg;
    logic [DW-1:0]      ret_data;

    region_decode u_region_decode (
        .nib    (g_addr[AW-1 -: 4]),
        .region (g_reg)
    );

    // Reset gates the request side so grants and IO strobes drop immediately.
    always_comb begin
        any_req = (m0_req | m1_req) & ~rst;
`ifdef ARB_CPU_PRIORITY_EN
        sel = ~m0_req;
`else
        sel = (m0_req & m1_req) ? ~last_q : m1_req;
`endif
        g_addr  = sel ? m1_addr  : m0_addr;
        g_wdata = sel ? m1_wdata : m0_wdata;
        g_we    = sel ? m1_we    : m0_we;
        g_read  = (g_we == 4'b0000);
        grant   = (state_q == ST_IDLE) && any_req;
        g_io    = grant && (g_reg == REG_IO);
    end

    always_comb begin
        m0_gnt    = grant & ~sel;
        m1_gnt    = grant & sel;
        mem_addr  = (state_q == ST_IO_WAIT) ? io_addr_q  : g_addr;
        mem_wdata = (state_q == ST_IO_WAIT) ? io_wdata_q : g_wdata;
        dmem_en   = grant && (g_reg == REG_DMEM);
        dmem_we   = dmem_en ? g_we : 4'b0000;
        bios_en   = grant && (g_reg == REG_BIOS) && g_read;
        io_req    = (state_q == ST_IO_WAIT) || g_io;
        io_we     = (state_q == ST_IO_WAIT) ? io_we_q : (g_io && !g_read);
    end

    always_comb begin
        state_d   = state_q;
        rv_d      = 1'b0;
        rv_own_d  = rv_own_q;
        rv_reg_d  = rv_reg_q;
        io_data_d = io_data_q;
        case (state_q)
            ST_IDLE: begin
                if (g_io) begin
                    if (io_ack) begin
                        if (g_read) begin
                            rv_d      = 1'b1;
                            rv_own_d  = OWN_W'(sel);
                            rv_reg_d  = REG_IO;
                            io_data_d = io_dout;
                        end
                    end else begin
                        state_d = ST_IO_WAIT;
                    end
                end else if (grant && g_read) begin
                    rv_d     = 1'b1;
                    rv_own_d = OWN_W'(sel);
                    rv_reg_d = g_reg;
                end
            end
            ST_IO_WAIT: begin
                if (io_ack) begin
                    state_d = ST_IDLE;
                    if (!io_we_q) begin
                        rv_d      = 1'b1;
                        rv_own_d  = io_own_q;
                        rv_reg_d  = REG_IO;
                        io_data_d = io_dout;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            rv_q       <= 1'b0;
            rv_own_q   <= '0;
            rv_reg_q   <= REG_DMEM;
            io_data_q  <= '0;
            io_addr_q  <= '0;
            io_wdata_q <= '0;
            io_we_q    <= 1'b0;
            io_own_q   <= '0;
        end else begin
            state_q   <= state_d;
            rv_q      <= rv_d;
            rv_own_q  <= rv_own_d;
            rv_reg_q  <= rv_reg_d;
            io_data_q <= io_data_d;
            if (grant)
                last_q <= sel;
            if (g_io) begin
                io_addr_q  <= g_addr;
                io_wdata_q <= g_wdata;
                io_we_q    <= ~g_read;
                io_own_q   <= OWN_W'(sel);
            end
        end
    end

    // DMEM/BIOS data arrives straight from the macro; IO data was captured on io_ack.
    always_comb begin
        case (rv_reg_q)
            REG_DMEM: ret_data = dmem_dout;
            REG_BIOS: ret_data = bios_dout;
            REG_IO:   ret_data = io_data_q;
            default:  ret_data = '0;
        endcase
        m0_rvalid = rv_q && (rv_own_q == OWN_W'(0));
        m1_rvalid = rv_q && (rv_own_q == OWN_W'(1));
        m0_rdata  = m0_rvalid ? ret_data : '0;
        m1_rdata  = m1_rvalid ? ret_data : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences, random vs model.
module tb_mem_port_arbiter;
    import arb_pkg::*;

`ifdef ARB_CPU_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [3:0]  m0_we, m1_we, dmem_we;
    logic [31:0] mem_addr, mem_wdata, dmem_dout, bios_dout, io_dout;
    logic        dmem_en, bios_en, io_req, io_we, io_ack;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .dmem_en(dmem_en), .dmem_we(dmem_we),
        .bios_en(bios_en), .io_req(io_req), .io_we(io_we), .io_ack(io_ack),
        .dmem_dout(dmem_dout), .bios_dout(bios_dout), .io_dout(io_dout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_addr = 0; m0_wdata = 0; m0_we = 0;
        m1_req = 0; m1_addr = 0; m1_wdata = 0; m1_we = 0;
        io_ack = 0; dmem_dout = 0; bios_dout = 0; io_dout = 0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic rst_dut();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // 0 DMEM, 1 BIOS, 2 IO, 3 unmapped
    function automatic int kind_of(input logic [31:0] a);
        case (a[31:28])
            4'h1, 4'h3: return 0;
            4'h4:       return 1;
            4'h8:       return 2;
            default:    return 3;
        endcase
    endfunction

    typedef struct {
        logic        r0, r1;
        logic [31:0] a0, a1;
        logic [3:0]  w0, w1;
        logic        eg0, eg1, eden;
        logic [3:0]  edwe;
        logic        ebios, eio, eiowe;
    } vec_t;

    vec_t vt[10];

    // random-phase model state
    logic        pend[2];
    logic [31:0] p_addr[2], p_wdata[2];
    logic [3:0]  p_we[2];
    int          m_last, m_io_own, io_cnt, ret_own, ret_kind, g, k;
    logic        m_wait, m_io_read, ret_v, ack, e_rv0, e_rv1;
    logic [31:0] m_io_addr, m_io_wdata, ret_data, e_data;

    initial begin
        logic [31:0] nib_tab [5];
        int prev_own, exp_own;

        vt[0] = '{0,0, 32'h0, 32'h0, 4'h0, 4'h0, 0,0,0, 4'h0, 0,0,0};
        vt[1] = '{1,0, 32'h1000_0000, 32'h0, 4'h0, 4'h0, 1,0,1, 4'h0, 0,0,0};
        vt[2] = '{0,1, 32'h0, 32'h3000_0010, 4'h0, 4'h3, 0,1,1, 4'h3, 0,0,0};
        vt[3] = '{1,0, 32'h4000_0100, 32'h0, 4'h0, 4'h0, 1,0,0, 4'h0, 1,0,0};
        vt[4] = '{0,1, 32'h0, 32'h4000_0200, 4'h0, 4'hC, 0,1,0, 4'h0, 0,0,0};
        vt[5] = '{1,0, 32'h8000_0000, 32'h0, 4'hF, 4'h0, 1,0,0, 4'h0, 0,1,1};
        vt[6] = '{0,1, 32'h0, 32'h8000_0004, 4'h0, 4'h0, 0,1,0, 4'h0, 0,1,0};
        vt[7] = '{1,0, 32'h2000_0000, 32'h0, 4'h0, 4'h0, 1,0,0, 4'h0, 0,0,0};
        vt[8] = '{0,1, 32'h0, 32'hF000_0000, 4'h0, 4'h1, 0,1,0, 4'h0, 0,0,0};
        vt[9] = '{1,0, 32'h5000_0000, 32'h0, 4'h0, 4'h0, 1,0,0, 4'h0, 0,0,0};

        rst = 1'b1;
        idle_inputs();
        rst_dut();
        sample();
        chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
        chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
        chk("rst_rdata", m0_rdata | m1_rdata, 0);
        chk("rst_en", {dmem_en, bios_en, io_req, dmem_we}, 0);

        // Single-cycle vectors; io_ack held high so IO completes in the grant cycle.
        for (int i = 0; i < 10; i++) begin
            next_cyc();
            m0_req = vt[i].r0; m0_addr = vt[i].a0; m0_we = vt[i].w0; m0_wdata = 32'h1111_0000 + i;
            m1_req = vt[i].r1; m1_addr = vt[i].a1; m1_we = vt[i].w1; m1_wdata = 32'h2222_0000 + i;
            io_ack = 1'b1;
            sample();
            chk($sformatf("vec%0d_gnt", i), {m0_gnt, m1_gnt}, {vt[i].eg0, vt[i].eg1});
            chk($sformatf("vec%0d_dmem", i), {dmem_en, dmem_we}, {vt[i].eden, vt[i].edwe});
            chk($sformatf("vec%0d_bios", i), bios_en, vt[i].ebios);
            chk($sformatf("vec%0d_io", i), {io_req, io_we}, {vt[i].eio, vt[i].eiowe});
            if (vt[i].r0 || vt[i].r1)
                chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].r0 ? vt[i].a0 : vt[i].a1);
        end
        next_cyc();
        idle_inputs();

        // DMEM read with one-cycle return
        rst_dut();
        m0_req = 1; m0_addr = 32'h1000_0004; dmem_dout = 32'hDEAD_BEEF;
        sample();
        chk("rd_gnt", m0_gnt, 1);
        chk("rd_en", dmem_en, 1);
        chk("rd_addr", mem_addr, 32'h1000_0004);
        next_cyc();
        m0_req = 0;
        sample();
        chk("rd_rvalid", m0_rvalid, 1);
        chk("rd_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("rd_m1_rvalid", m1_rvalid, 0);
        next_cyc();

        // Tie arbitration over 4 cycles, returns routed to owner
        rst_dut();
        prev_own = 0;
        for (int i = 0; i < 5; i++) begin
            m0_req = (i < 4); m1_req = (i < 4);
            m0_addr = 32'h1000_0100; m1_addr = 32'h3000_0200;
            dmem_dout = 32'hA000_0000 + i;
            sample();
            exp_own = PRIO ? 0 : (i % 2);
            if (i < 4)
                chk($sformatf("tie%0d_gnt", i), {m0_gnt, m1_gnt}, exp_own == 0 ? 2'b10 : 2'b01);
            if (i > 0) begin
                chk($sformatf("tie%0d_rv", i), {m0_rvalid, m1_rvalid}, prev_own == 0 ? 2'b10 : 2'b01);
                chk($sformatf("tie%0d_rdata", i), prev_own == 0 ? m0_rdata : m1_rdata, 32'hA000_0000 + i);
            end
            prev_own = exp_own;
            next_cyc();
        end
        idle_inputs();

        // IO read with 3-cycle ack, m0 blocked during wait
        m1_req = 1; m1_addr = 32'h8000_0010;
        sample();
        chk("io_gnt", m1_gnt, 1);
        chk("io_req_t0", {io_req, io_we}, 2'b10);
        next_cyc();
        m1_req = 0; m0_req = 1; m0_addr = 32'h1000_0040;
        for (int k2 = 1; k2 < 3; k2++) begin
            sample();
            chk($sformatf("io_wait%0d", k2), {io_req, m0_gnt, m1_gnt}, 3'b100);
            chk($sformatf("io_hold%0d", k2), mem_addr, 32'h8000_0010);
            next_cyc();
        end
        io_ack = 1; io_dout = 32'h55;
        sample();
        chk("io_ack_cyc", {io_req, m0_gnt}, 2'b10);
        next_cyc();
        io_ack = 0; io_dout = 32'h0;
        sample();
        chk("io_rv", {m1_rvalid, m0_rvalid}, 2'b10);
        chk("io_rdata", m1_rdata, 32'h55);
        chk("io_next_gnt", {m0_gnt, io_req}, 2'b10);
        next_cyc();
        idle_inputs();
        next_cyc();

        // BIOS write dropped, unmapped read returns zero
        m0_req = 1; m0_addr = 32'h4000_0000; m0_we = 4'hF;
        dmem_dout = 32'h1234_5678; bios_dout = 32'h9ABC_DEF0;
        sample();
        chk("bw_gnt", m0_gnt, 1);
        chk("bw_en", {bios_en, dmem_en, dmem_we}, 0);
        next_cyc();
        m0_req = 0; m0_we = 0;
        sample();
        chk("bw_norv", {m0_rvalid, m1_rvalid}, 0);
        next_cyc();
        m0_req = 1; m0_addr = 32'h2000_0000;
        sample();
        chk("nr_gnt", {m0_gnt, dmem_en, bios_en, io_req}, 4'b1000);
        next_cyc();
        m0_req = 0;
        sample();
        chk("nr_rv", m0_rvalid, 1);
        chk("nr_rdata", m0_rdata, 0);
        next_cyc();

        // Reset in the middle of an IO wait
        m0_req = 1; m0_addr = 32'h8000_0000;
        sample();
        chk("rio_gnt", m0_gnt, 1);
        next_cyc();
        m0_req = 0; m1_req = 1; m1_addr = 32'h1000_0000;
        sample();
        chk("rio_wait", {io_req, m1_gnt}, 2'b10);
        #1 rst = 1'b1;
        #1;
        chk("rio_drop", {io_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        m1_req = 0; m0_req = 1; m0_addr = 32'h1000_0008;
        sample();
        chk("rio_first_gnt", {m0_gnt, dmem_en}, 2'b11);
        next_cyc();
        m0_req = 0;
        sample();
        chk("rio_rv", {m0_rvalid, m1_rvalid}, 2'b10);
        next_cyc();

        // Randomized traffic against the model
        rst_dut();
        nib_tab[0] = 32'h1; nib_tab[1] = 32'h3; nib_tab[2] = 32'h4; nib_tab[3] = 32'h8; nib_tab[4] = 32'h2;
        pend[0] = 0; pend[1] = 0;
        m_last = 1; m_wait = 0; io_cnt = 0; ret_v = 0; ret_own = 0; ret_kind = 0; ret_data = 0;
        m_io_own = 0; m_io_read = 0; m_io_addr = 0; m_io_wdata = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    logic [31:0] nb;
                    nb = ($urandom_range(0, 5) == 5) ? 32'hF : nib_tab[$urandom_range(0, 4)];
                    pend[p]    = 1;
                    p_addr[p]  = {nb[3:0], 28'($urandom)};
                    p_we[p]    = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                    p_wdata[p] = $urandom;
                end
            end
            m0_req = pend[0]; m0_addr = p_addr[0]; m0_we = p_we[0]; m0_wdata = p_wdata[0];
            m1_req = pend[1]; m1_addr = p_addr[1]; m1_we = p_we[1]; m1_wdata = p_wdata[1];
            dmem_dout = $urandom; bios_dout = $urandom; io_dout = $urandom;

            g = -1;
            if (!m_wait) begin
                if (pend[0] && pend[1]) g = PRIO ? 0 : (m_last == 1 ? 0 : 1);
                else if (pend[0])       g = 0;
                else if (pend[1])       g = 1;
            end
            k = (g >= 0) ? kind_of(p_addr[g]) : 3;

            ack = 0;
            if (m_wait) begin
                if (io_cnt == 0) ack = 1; else io_cnt--;
            end else if (g >= 0 && k == 2) begin
                io_cnt = $urandom_range(0, 3);
                if (io_cnt == 0) ack = 1; else io_cnt--;
            end else begin
                ack = ($urandom_range(0, 7) == 0);
            end
            io_ack = ack;

            sample();
            e_rv0 = ret_v && ret_own == 0;
            e_rv1 = ret_v && ret_own == 1;
            case (ret_kind)
                0: e_data = dmem_dout;
                1: e_data = bios_dout;
                2: e_data = ret_data;
                default: e_data = 0;
            endcase
            chk("rnd_gnt", {m0_gnt, m1_gnt}, {g == 0, g == 1});
            chk("rnd_rv", {m0_rvalid, m1_rvalid}, {e_rv0, e_rv1});
            chk("rnd_rdata0", m0_rdata, e_rv0 ? e_data : 32'h0);
            chk("rnd_rdata1", m1_rdata, e_rv1 ? e_data : 32'h0);
            chk("rnd_io", {io_req, io_we},
                m_wait ? {1'b1, !m_io_read} : {g >= 0 && k == 2, g >= 0 && k == 2 && p_we[g] != 0});
            chk("rnd_dmem", {dmem_en, dmem_we},
                (g >= 0 && k == 0) ? {1'b1, p_we[g]} : 5'b0);
            chk("rnd_bios", bios_en, g >= 0 && k == 1 && p_we[g] == 0);
            if (m_wait) begin
                chk("rnd_hold_addr", mem_addr, m_io_addr);
                chk("rnd_hold_wdata", mem_wdata, m_io_wdata);
            end else if (g >= 0) begin
                chk("rnd_addr", mem_addr, p_addr[g]);
                chk("rnd_wdata", mem_wdata, p_wdata[g]);
            end

            ret_v = 0;
            if (m_wait) begin
                if (ack) begin
                    m_wait = 0;
                    if (m_io_read) begin
                        ret_v = 1; ret_own = m_io_own; ret_kind = 2; ret_data = io_dout;
                    end
                end
            end else if (g >= 0) begin
                m_last = g;
                pend[g] = 0;
                if (k == 2) begin
                    if (ack) begin
                        if (p_we[g] == 0) begin
                            ret_v = 1; ret_own = g; ret_kind = 2; ret_data = io_dout;
                        end
                    end else begin
                        m_wait = 1; m_io_own = g; m_io_read = (p_we[g] == 0);
                        m_io_addr = p_addr[g]; m_io_wdata = p_wdata[g];
                    end
                end else if (p_we[g] == 0) begin
                    ret_v = 1; ret_own = g; ret_kind = k;
                end
            end
            next_cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
